uart_rx: RTL

//   UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN). Oversamples rx_pin with the system clock.

---
 rtl/uart_rx.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is
// defined).
//
// The asynchronous rx_pin is brought into the clk domain through a 2-flop
// synchroniser. A history flop behind it detects the falling edge of a start
// bit. The start bit is confirmed at its midpoint, which rejects short glitches.
// Every later bit is then sampled one full bit time after the previous sample,
// so each sample falls mid-bit. A completed byte is offered on a valid/ready
// handshake.
//
// Optional feature macro:
//   UART_RX_PARITY_EN  adds an even-parity bit between the data and the stop
//                      bit. A parity mismatch is reported as a frame error.
//
// Parameters:
//   clk_fre     system clock frequency in MHz
//   baud_rate   line rate in bit/s
//
// Ports:
//   clk            in   system clock; all logic is on the rising edge
//   rst            in   synchronous, active-high reset
//   rx_pin         in   asynchronous serial input, idles high
//   rx_data        out  received byte; the line carries it LSB first
//   rx_data_valid  out  rx_data holds a byte that has not been consumed
//   rx_data_ready  in   consumer takes the byte when high while valid is high
//   rx_frame_err   out  1-clk pulse: bad stop bit (or bad parity)
//   rx_overrun     out  1-clk pulse: a new byte replaced an unconsumed one
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int clk_fre   = 100,
    parameter int baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    // Clocks per bit. The product is formed in 64 bits so that fast clocks
    // cannot overflow it.
    localparam int CYCLE = int'((64'(clk_fre) * 64'd1000000) / 64'(baud_rate));
    localparam int CNT_W = (CYCLE > 2) ? $clog2(CYCLE) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT_HI
    } state_t;

    // Input synchroniser and edge history
    logic             sync1_q;
    logic             sync2_q;
    logic             hist_q;

    // Frame sequencing
    state_t           state_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shreg_q;
    logic [7:0]       shreg_d;

    // Registered outputs
    logic [7:0]       data_q;
    logic             valid_q;
    logic             frame_err_q;
    logic             overrun_q;

`ifdef UART_RX_PARITY_EN
    logic             par_err_q;
`endif

    logic             fall_edge;
    logic             bit_end;
    logic             accept;
    logic             stop_ok;

    assign fall_edge = hist_q & ~sync2_q;
    assign bit_end   = (cycle_cnt_q == BIT_LAST);
    assign accept    = valid_q & rx_data_ready;

`ifdef UART_RX_PARITY_EN
    // A high stop bit is still rejected when the parity check has failed.
    assign stop_ok = sync2_q & ~par_err_q;
`else
    assign stop_ok = sync2_q;
`endif

    // Shift register with the current mid-bit sample written into its slot.
    always_comb begin
        // NOTE: default first so every path assigns shreg_d; otherwise a latch is inferred.
        shreg_d            = shreg_q;
        shreg_d[bit_cnt_q] = sync2_q;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every flop samples the pre-edge values.
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            hist_q      <= 1'b1;
            state_q     <= S_IDLE;
            cycle_cnt_q <= '0;
            bit_cnt_q   <= '0;
            // NOTE: the shift register is reset as well. It is only 8 flops,
            // and the reset keeps its contents deterministic in simulation.
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            sync1_q     <= rx_pin;
            sync2_q     <= sync1_q;
            hist_q      <= sync2_q;

            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;

            // Consumption. A byte that completes in the same cycle overrides
            // this clear further down.
            if (accept) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (fall_edge) begin
                        state_q     <= S_START;
                        cycle_cnt_q <= '0;
                    end
                end

                S_START: begin
                    if (cycle_cnt_q == HALF_LAST) begin
                        cycle_cnt_q <= '0;
                        bit_cnt_q   <= '0;
                        // A line that is high again at mid start bit was a glitch.
                        state_q     <= sync2_q ? S_IDLE : S_DATA;
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        cycle_cnt_q <= '0;
                        shreg_q     <= shreg_d;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                    end
                end

`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        cycle_cnt_q <= '0;
                        // Even parity: data and parity bit together hold an even number of ones.
                        par_err_q   <= ^{shreg_q, sync2_q};
                        state_q     <= S_STOP;
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (bit_end) begin
                        cycle_cnt_q <= '0;
                        if (stop_ok) begin
                            data_q    <= shreg_q;
                            valid_q   <= 1'b1;
                            // Simultaneous consumption makes room, so that case is not an overrun.
                            overrun_q <= valid_q & ~rx_data_ready;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        // A stop bit that is still low may be a break. Wait for
                        // the line to rise before arming the start detector again.
                        state_q <= sync2_q ? S_IDLE : S_WAIT_HI;
                    end else begin
                        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                    end
                end

                S_WAIT_HI: begin
                    if (sync2_q) begin
                        state_q     <= S_IDLE;
                        cycle_cnt_q <= '0;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    cycle_cnt_q <= '0;
                end
            endcase
        end
    end

    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;
    assign rx_frame_err  = frame_err_q;
    assign rx_overrun    = overrun_q;

endmodule
